// File: rtl/sgemm_ctrl_pkg.sv
// Shared types and configuration helpers for the SGEMM job sequencer.
package sgemm_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ALIGN,
    FILL,
    RUN,
    DONE
  } ctrl_state_t;

  // The job counter must be wide enough for one block and for the drain window.
  function automatic bit cnt_width_ok(input int cnt_w, input int blk_log2, input int drain_cyc);
    return (cnt_w > blk_log2) && (cnt_w >= $clog2(drain_cyc + 1));
  endfunction

endpackage

// File: rtl/sgemm_ctrl_dly.sv
// Clearable shift register that times the feeder-to-PE alignment window.
module sgemm_ctrl_dly #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr;

  generate
    if (DEPTH == 1) begin : g_one
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sr <= '0;
        else          sr <= clr ? 1'b0 : din;
      end
    end else begin : g_many
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sr <= '0;
        else          sr <= clr ? '0 : {sr[DEPTH-2:0], din};
      end
    end
  endgenerate

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/sgemm_ctrl_seq.sv
// SGEMM job sequencer: feeder wait, PE alignment, block run with drain stall, done pulse.
// Optional SGEMM_CTRL_PERF_EN adds run/stall cycle counters.
module sgemm_ctrl_seq
  import sgemm_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 24,
  parameter int BLK_LOG2   = 14,
  parameter int DRAIN_CYC  = 1024,
  parameter int START_DLY  = 3,
  parameter int PE_LAT     = 23,
  parameter int CRD_LEAD   = 998
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] workloads_num,
  input  logic                  loaded_a,
  input  logic                  loaded_b,
  input  logic                  results_afull,
  output logic                  read_mem,
  output logic                  start_calc,
  output logic                  cache_fifo_read,
  output logic                  cache_fifo_write,
  output logic                  results_fifo_write,
  output logic                  busy,
`ifdef SGEMM_CTRL_PERF_EN
  output logic [31:0]           perf_run_cyc,
  output logic [31:0]           perf_stall_cyc,
`endif
  output logic                  done
);

  localparam bit CFG_OK = cnt_width_ok(CNT_WIDTH, BLK_LOG2, DRAIN_CYC);

  ctrl_state_t           state, next_state;
  logic [CNT_WIDTH-1:0]  cnt, cnt_d;
  logic [DATA_WIDTH-1:0] wl_q;
  logic                  en_q;
  logic [CNT_WIDTH-1:0]  total;
  logic                  en_start, rdy, stall, adv, run_ok, dly_out;
  logic                  read_mem_d, start_calc_d, cache_rd_d, cache_wr_d, res_wr_d, busy_d, done_d;

  // A misconfigured counter width never accepts a job.
  assign en_start = en && !en_q && CFG_OK;
  assign total    = CNT_WIDTH'(wl_q << BLK_LOG2);
  assign rdy      = ({1'b0, cnt} + (CNT_WIDTH+1)'(DRAIN_CYC)) >= {1'b0, total};
  assign stall    = (state == RUN) && results_afull && rdy;
  assign adv      = (state == RUN) && !stall;

  sgemm_ctrl_dly #(.DEPTH(START_DLY + 1)) u_dly (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (next_state != ALIGN),
    .din     ((state == LOAD) && (next_state == ALIGN)),
    .dout    (dly_out)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      wl_q  <= '0;
      en_q  <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= cnt_d;
      en_q  <= en;
      if (state == IDLE && en_start) wl_q <= workloads_num;
    end
  end

  always_comb begin
    next_state = state;
    cnt_d      = cnt;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (en_start) next_state = (workloads_num == '0) ? DONE : LOAD;
      end
      LOAD: begin
        if (!en)                       next_state = IDLE;
        else if (loaded_a && loaded_b) next_state = ALIGN;
      end
      ALIGN: begin
        if (!en) next_state = IDLE;
        else if (dly_out) begin
          next_state = FILL;
          cnt_d      = '0;
        end
      end
      FILL: begin
        if (!en) next_state = IDLE;
        else if (cnt == CNT_WIDTH'(PE_LAT - 1)) begin
          next_state = RUN;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      RUN: begin
        if (!en) next_state = IDLE;
        else if (adv) begin
          cnt_d = cnt + 1'b1;
          if (cnt == total - 1'b1) next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (next_state == IDLE) cnt_d = '0;
  end

  // Output values for the next cycle; strobes follow the counter value that advanced.
  always_comb begin
    run_ok       = adv && en;
    cache_wr_d   = run_ok && !rdy;
    res_wr_d     = run_ok && rdy;
    cache_rd_d   = run_ok && !rdy && (cnt >= CNT_WIDTH'(CRD_LEAD));
    read_mem_d   = (next_state == LOAD) || (next_state == ALIGN) ||
                   (next_state == FILL) || (next_state == RUN);
    start_calc_d = (next_state == FILL) || ((next_state == RUN) && !stall);
    busy_d       = (next_state != IDLE);
    done_d       = (next_state == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      read_mem           <= 1'b0;
      start_calc         <= 1'b0;
      cache_fifo_read    <= 1'b0;
      cache_fifo_write   <= 1'b0;
      results_fifo_write <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
    end else begin
      read_mem           <= read_mem_d;
      start_calc         <= start_calc_d;
      cache_fifo_read    <= cache_rd_d;
      cache_fifo_write   <= cache_wr_d;
      results_fifo_write <= res_wr_d;
      busy               <= busy_d;
      done               <= done_d;
    end
  end

`ifdef SGEMM_CTRL_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_run_cyc   <= '0;
      perf_stall_cyc <= '0;
    end else if (state == IDLE && next_state == LOAD) begin
      perf_run_cyc   <= '0;
      perf_stall_cyc <= '0;
    end else if (state == RUN) begin
      if (perf_run_cyc != '1)            perf_run_cyc   <= perf_run_cyc + 1'b1;
      if (stall && perf_stall_cyc != '1) perf_stall_cyc <= perf_stall_cyc + 1'b1;
    end
  end
`endif

endmodule
